// File: rtl/sap2_seq_pkg.sv
// Shared definitions for the SAP-2 T-state sequencer: state encoding and
// default ring geometry.
package sap2_seq_pkg;

   typedef enum logic [1:0] {
      SEQ_RUN       = 2'd0,
      SEQ_STEP_WAIT = 2'd1,
      SEQ_HALT      = 2'd2
   } seqState_t;

   localparam int SEQ_NUM_T_DEFAULT = 18;
   localparam int SEQ_MIN_T_DEFAULT = 3;
   localparam int SEQ_COUNT_W       = 16;

endpackage

// File: rtl/var_ring_sequencer_tstate_decoder.sv
// Binary T index to one-hot T-state, forced to all-zero when not running.
module tstate_decoder
   import sap2_seq_pkg::*;
#(
   parameter int NUM_T = SEQ_NUM_T_DEFAULT,
   parameter int T_W   = $clog2(NUM_T)
) (
   input  logic [T_W-1:0]   tIdx,
   input  logic             runEn,
   output logic [NUM_T-1:0] tState
);

   always_comb begin
      tState = '0;
      if (runEn) begin
         tState[tIdx] = 1'b1;
      end
   end

endmodule

// File: rtl/var_ring_sequencer.sv
// Variable-length T-state ring for the SAP-2 control unit, with wait stretch,
// halt, and single-instruction step mode.
module var_ring_sequencer
   import sap2_seq_pkg::*;
#(
   parameter  int NUM_T = SEQ_NUM_T_DEFAULT,
   parameter  int MIN_T = SEQ_MIN_T_DEFAULT,
   localparam int T_W   = $clog2(NUM_T)
) (
   input  logic                   inCLK,
   input  logic                   inRST,
   input  logic                   inEnd,
   input  logic                   inWait,
   input  logic                   inHLT,
   input  logic                   inStepMode,
   input  logic                   inStepPulse,
   output logic [NUM_T-1:0]       oTstate,
   output logic [T_W-1:0]         oTidx,
   output logic                   oFetch,
   output logic                   oLastT,
   output logic                   oHLT,
   output logic [SEQ_COUNT_W-1:0] oInstrCount
);

   localparam logic [T_W-1:0] FIRST_FREE = T_W'(MIN_T);
   localparam logic [T_W-1:0] LAST_IDX   = T_W'(NUM_T - 1);

   seqState_t              state;
   logic [T_W-1:0]         tIdx;
   logic [SEQ_COUNT_W-1:0] instrCount;
   logic                   stepPrev;
   logic                   hltReg;
   logic                   running;
   logic                   pastFetch;
   logic                   lastT;
   logic                   stepEdge;

   // The early end request only counts once the fixed fetch window is over;
   // the final ring slot always ends the instruction so the index wraps.
   always_comb begin
      running   = (state == SEQ_RUN);
      pastFetch = (tIdx >= FIRST_FREE);
      lastT     = running && ((inEnd && pastFetch) || (tIdx == LAST_IDX));
      stepEdge  = inStepPulse && !stepPrev;
   end

   always_ff @(posedge inCLK or negedge inRST) begin
      if (!inRST) begin
         state      <= SEQ_RUN;
         tIdx       <= '0;
         instrCount <= '0;
         stepPrev   <= 1'b0;
         hltReg     <= 1'b0;
      end else begin
         stepPrev <= inStepPulse;
         case (state)
            SEQ_RUN: begin
               if (inWait) begin
                  tIdx <= tIdx;
               end else if (inHLT && pastFetch) begin
                  state  <= SEQ_HALT;
                  hltReg <= 1'b1;
               end else if (lastT) begin
                  tIdx       <= '0;
                  instrCount <= instrCount + SEQ_COUNT_W'(1);
                  if (inStepMode) begin
                     state <= SEQ_STEP_WAIT;
                  end
               end else begin
                  tIdx <= tIdx + T_W'(1);
               end
            end
            SEQ_STEP_WAIT: begin
               if (!inStepMode || stepEdge) begin
                  state <= SEQ_RUN;
               end
            end
            SEQ_HALT: begin
               hltReg <= 1'b1;
            end
            default: begin
               state <= SEQ_RUN;
               tIdx  <= '0;
            end
         endcase
      end
   end

   tstate_decoder #(
      .NUM_T (NUM_T),
      .T_W   (T_W)
   ) uDecoder (
      .tIdx   (tIdx),
      .runEn  (running),
      .tState (oTstate)
   );

   assign oTidx       = tIdx;
   assign oFetch      = running && !pastFetch;
   assign oLastT      = lastT;
   assign oHLT        = hltReg;
   assign oInstrCount = instrCount;

endmodule

// File: tb/tb_var_ring_sequencer.sv
// Directed self-checking bench for var_ring_sequencer with default geometry
// (18 T-states, 3 fetch states).
module tb_var_ring_sequencer;

   logic        inCLK = 1'b0;
   logic        inRST;
   logic        inEnd;
   logic        inWait;
   logic        inHLT;
   logic        inStepMode;
   logic        inStepPulse;
   logic [17:0] oTstate;
   logic [4:0]  oTidx;
   logic        oFetch;
   logic        oLastT;
   logic        oHLT;
   logic [15:0] oInstrCount;

   int checks   = 0;
   int failures = 0;

   var_ring_sequencer dut (
      .inCLK       (inCLK),
      .inRST       (inRST),
      .inEnd       (inEnd),
      .inWait      (inWait),
      .inHLT       (inHLT),
      .inStepMode  (inStepMode),
      .inStepPulse (inStepPulse),
      .oTstate     (oTstate),
      .oTidx       (oTidx),
      .oFetch      (oFetch),
      .oLastT      (oLastT),
      .oHLT        (oHLT),
      .oInstrCount (oInstrCount)
   );

   always #5 inCLK = ~inCLK;

   // Advance n rising edges and settle just past the last one.
   task automatic applyStimulus(input int n);
      repeat (n) @(posedge inCLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      inRST = 1'b0; inEnd = 1'b0; inWait = 1'b0; inHLT = 1'b0;
      inStepMode = 1'b0; inStepPulse = 1'b0;
      #3;
      checkOutput("rst_tstate", 32'(oTstate), 32'h1);
      checkOutput("rst_tidx", 32'(oTidx), 32'd0);
      checkOutput("rst_count", 32'(oInstrCount), 32'd0);
      checkOutput("rst_hlt", 32'(oHLT), 32'd0);
      checkOutput("rst_fetch", 32'(oFetch), 32'd1);
      applyStimulus(2);
      checkOutput("rst_hold_tidx", 32'(oTidx), 32'd0);
      inRST = 1'b1;

      // Full ring walk with no early end
      for (int i = 0; i < 18; i++) begin
         checkOutput($sformatf("walk_t%0d", i), 32'(oTstate), 32'(1) << i);
         if (i == 17) checkOutput("walk_lastT", 32'(oLastT), 32'd1);
         applyStimulus(1);
      end
      checkOutput("walk_wrap_tstate", 32'(oTstate), 32'h1);
      checkOutput("walk_wrap_count", 32'(oInstrCount), 32'd1);

      // End ignored in fetch, honoured after it
      applyStimulus(1);
      inEnd = 1'b1; #1;
      checkOutput("end_fetch_lastT", 32'(oLastT), 32'd0);
      applyStimulus(1);
      checkOutput("end_fetch_tidx", 32'(oTidx), 32'd2);
      checkOutput("end_fetch_count", 32'(oInstrCount), 32'd1);
      inEnd = 1'b0;
      applyStimulus(2);
      inEnd = 1'b1; #1;
      checkOutput("end_t4_lastT", 32'(oLastT), 32'd1);
      applyStimulus(1);
      inEnd = 1'b0;
      checkOutput("end_t4_tidx", 32'(oTidx), 32'd0);
      checkOutput("end_t4_count", 32'(oInstrCount), 32'd2);

      // Wait freezes the index
      applyStimulus(2);
      checkOutput("wait_pre_fetch", 32'(oFetch), 32'd1);
      inWait = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1);
         checkOutput($sformatf("wait_hold%0d", i), 32'(oTidx), 32'd2);
      end
      inWait = 1'b0;
      applyStimulus(1);
      checkOutput("wait_release_tidx", 32'(oTidx), 32'd3);
      checkOutput("wait_release_fetch", 32'(oFetch), 32'd0);
      inWait = 1'b1; inHLT = 1'b1;
      applyStimulus(1);
      checkOutput("wait_over_hlt_tidx", 32'(oTidx), 32'd3);
      checkOutput("wait_over_hlt_hlt", 32'(oHLT), 32'd0);

      // Halt at T3, then everything ignored until reset
      inWait = 1'b0;
      applyStimulus(1);
      checkOutput("hlt_flag", 32'(oHLT), 32'd1);
      checkOutput("hlt_tstate", 32'(oTstate), 32'd0);
      checkOutput("hlt_tidx", 32'(oTidx), 32'd3);
      checkOutput("hlt_lastT", 32'(oLastT), 32'd0);
      inEnd = 1'b1; inHLT = 1'b0; inStepMode = 1'b1; inStepPulse = 1'b1;
      applyStimulus(3);
      checkOutput("hlt_stay_flag", 32'(oHLT), 32'd1);
      checkOutput("hlt_stay_tstate", 32'(oTstate), 32'd0);
      checkOutput("hlt_stay_tidx", 32'(oTidx), 32'd3);
      checkOutput("hlt_stay_count", 32'(oInstrCount), 32'd2);
      inRST = 1'b0; #1;
      checkOutput("hlt_rst_tstate", 32'(oTstate), 32'h1);
      checkOutput("hlt_rst_flag", 32'(oHLT), 32'd0);
      checkOutput("hlt_rst_count", 32'(oInstrCount), 32'd0);
      inEnd = 1'b0; inStepMode = 1'b0; inStepPulse = 1'b0;
      applyStimulus(1);
      inRST = 1'b1;

      // Halt request during fetch is ignored; halt beats end afterwards
      inHLT = 1'b1;
      applyStimulus(1);
      checkOutput("hlt_fetch_t1", 32'(oTidx), 32'd1);
      applyStimulus(2);
      checkOutput("hlt_fetch_t3", 32'(oTidx), 32'd3);
      checkOutput("hlt_fetch_flag", 32'(oHLT), 32'd0);
      inEnd = 1'b1;
      applyStimulus(1);
      checkOutput("hlt_over_end_flag", 32'(oHLT), 32'd1);
      checkOutput("hlt_over_end_count", 32'(oInstrCount), 32'd0);
      inRST = 1'b0; inEnd = 1'b0; inHLT = 1'b0;
      applyStimulus(1);
      inRST = 1'b1;

      // Step mode: one instruction per step-pulse rising edge
      inStepMode = 1'b1;
      applyStimulus(5);
      checkOutput("step_t5", 32'(oTidx), 32'd5);
      inEnd = 1'b1;
      applyStimulus(1);
      inEnd = 1'b0;
      checkOutput("step_wait_tstate", 32'(oTstate), 32'd0);
      checkOutput("step_wait_tidx", 32'(oTidx), 32'd0);
      checkOutput("step_wait_count", 32'(oInstrCount), 32'd1);
      checkOutput("step_wait_fetch", 32'(oFetch), 32'd0);
      applyStimulus(2);
      checkOutput("step_idle_tstate", 32'(oTstate), 32'd0);
      inStepPulse = 1'b1;
      applyStimulus(1);
      checkOutput("step_release", 32'(oTstate), 32'h1);
      applyStimulus(3);
      checkOutput("step_run_t3", 32'(oTidx), 32'd3);
      inEnd = 1'b1;
      applyStimulus(1);
      inEnd = 1'b0;
      applyStimulus(4);
      checkOutput("step_held_tstate", 32'(oTstate), 32'd0);
      checkOutput("step_held_count", 32'(oInstrCount), 32'd2);
      inStepPulse = 1'b0;
      applyStimulus(1);
      checkOutput("step_low_tstate", 32'(oTstate), 32'd0);
      inStepPulse = 1'b1;
      applyStimulus(1);
      checkOutput("step_second_release", 32'(oTstate), 32'h1);
      applyStimulus(3);
      inEnd = 1'b1;
      applyStimulus(1);
      inEnd = 1'b0;
      checkOutput("step_third_wait", 32'(oTstate), 32'd0);
      inStepMode = 1'b0;
      applyStimulus(1);
      checkOutput("step_mode_off_tstate", 32'(oTstate), 32'h1);
      checkOutput("step_mode_off_count", 32'(oInstrCount), 32'd3);

      // Counter wrap at 16 bits, starting near the top of the range
      force dut.instrCount = 16'hFFFE;
      #1;
      release dut.instrCount;
      #1;
      checkOutput("wrap_preset", 32'(oInstrCount), 32'hFFFE);
      inEnd = 1'b1;
      applyStimulus(4);
      checkOutput("wrap_ffff", 32'(oInstrCount), 32'hFFFF);
      applyStimulus(4);
      checkOutput("wrap_zero", 32'(oInstrCount), 32'h0000);
      checkOutput("wrap_tidx", 32'(oTidx), 32'd0);
      inEnd = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
